// File: rtl/rr_job_arbiter_if.sv
// ----------------------------------------------------------------------------
// rr_job_arbiter_if
// Bundle of the requester-side and datapath-side signals of rr_job_arbiter.
//   req         requester -> arbiter   level request per requester
//   ack         arbiter -> requester   one-hot, one-cycle completion pulse
//   grant       arbiter -> requester   one-hot owner of the shared datapath
//   dp_start    arbiter -> datapath    one-cycle start pulse
//   dp_done     datapath -> arbiter    completion pulse
//   busy        arbiter -> system      high while a job is in flight
//   timeout_err arbiter -> requester   job aborted by watchdog (with ack)
// Modports: master = arbiter side, slave = requester/datapath side.
// ----------------------------------------------------------------------------
interface rr_job_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] req;
    logic [N-1:0] ack;
    logic [N-1:0] grant;
    logic         dp_start;
    logic         dp_done;
    logic         busy;
    logic         timeout_err;

    modport master (
        input  req, dp_done,
        output ack, grant, dp_start, busy, timeout_err
    );

    modport slave (
        output req, dp_done,
        input  ack, grant, dp_start, busy, timeout_err
    );
endinterface

// File: rtl/rr_job_arbiter.sv
// ----------------------------------------------------------------------------
// rr_job_arbiter
// Round-robin arbiter/sequencer sharing one start/done datapath among N
// requesters: pick a winner, pulse dp_start, wait for dp_done, pulse ack.
// Ports:
//   clock   system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     rr_job_arbiter_if.master (req, ack, grant, dp_start, dp_done,
//           busy, timeout_err)
// Parameters: N (requesters, >= 2), TIMEOUT (watchdog limit in WAIT cycles).
// Optional feature macro: ARB_TIMEOUT_EN -- builds the WAIT watchdog. When
// undefined, timeout_err is tied low and WAIT waits for dp_done forever.
// ----------------------------------------------------------------------------
module rr_job_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             rst_n,
    rr_job_arbiter_if.master bus
);
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_win;
    logic [N-1:0]    r_grant;
    logic [N-1:0]    r_ack;
    logic            r_dp_start;
    logic            r_busy;
    logic            w_wd_hit;
    logic            w_tmo;

    // Rotate requests so that bit 0 is the requester at ptr; the lowest set
    // bit of the rotated vector is the offset of the winner from ptr.
    logic [N-1:0]    w_rot;
    logic [PW-1:0]   w_off;
    logic            w_found;
    logic [PW:0]     w_sum;
    logic [PW-1:0]   w_win;

    assign w_rot = N'({bus.req, bus.req} >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_off   = PW'(i);
            end
        end
    end

    assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win = (w_sum >= (PW+1)'(N)) ? PW'(w_sum - (PW+1)'(N)) : PW'(w_sum);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_wd_cnt;
    logic          r_tmo_err;

    // Cleared while in ISSUE so it starts at 0 on the first WAIT cycle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_WAIT && !bus.dp_done) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_wd_hit = (r_wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_tmo_err <= 1'b0;
        else        r_tmo_err <= w_tmo;
    end

    assign bus.timeout_err = r_tmo_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo    = (TIMEOUT > 0);
    assign w_wd_hit        = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmo       = 1'b0;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // dp_done takes priority over a coincident watchdog expiry.
                if (bus.dp_done) begin
                    w_state_nxt = S_ACK;
                end else if (w_wd_hit) begin
                    w_state_nxt = S_ACK;
                    w_tmo       = 1'b1;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_grant    <= '0;
            r_win      <= '0;
            r_ptr      <= '0;
            r_ack      <= '0;
            r_dp_start <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_dp_start <= (w_state_nxt == S_ISSUE);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_ack      <= (w_state_nxt == S_ACK) ? r_grant : '0;
            if (r_state == S_IDLE && w_found) begin
                r_grant <= N'(1) << w_win;
                r_win   <= w_win;
            end else if (r_state == S_ACK) begin
                r_grant <= '0;
                r_ptr   <= (r_win == PW'(N - 1)) ? '0 : r_win + 1'b1;
            end
        end
    end

    assign bus.grant    = r_grant;
    assign bus.ack      = r_ack;
    assign bus.dp_start = r_dp_start;
    assign bus.busy     = r_busy;
endmodule

// File: doc/rr_job_arbiter.md
# rr_job_arbiter

Round-robin arbiter and sequencer that shares one start/done datapath controller (a Moore- or Mealy-style `top_*` unit) among N requesters. It picks one pending request, issues a single-cycle `dp_start` pulse to the shared unit, waits for its `dp_done` pulse, then returns a one-cycle acknowledge to the winning requester. It sits between the requester blocks and the shared controller, which has no arbitration of its own.

## Interface
- `N`, 4: number of requesters; must be 2 or more.
- `TIMEOUT`, 64: maximum number of WAIT cycles before the job is aborted. Used only when the configuration macro is defined.

- `clock`  in  1  single system clock; rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N  level request per requester; held high until its `ack`.
- `ack`  out  N  one-hot, one-cycle completion pulse to the granted requester.
- `grant`  out  N  one-hot owner of the datapath; held from dispatch through ACK.
- `dp_start`  out  1  one-cycle start pulse to the shared datapath.
- `dp_done`  in  1  completion pulse from the shared datapath.
- `busy`  out  1  high whenever state is not IDLE.
- `timeout_err`  out  1  high with `ack` when the job was aborted by the watchdog.

## Operation
- States: IDLE, ISSUE, WAIT, ACK. All outputs are registered Moore outputs.
- IDLE
  - If `req` is nonzero, pick a winner by round-robin, searching upward (with wrap-around) from `ptr`.
  - Load `grant` with the one-hot winner and go to ISSUE.
  - If `req` is zero, stay in IDLE.
- ISSUE: `dp_start` = 1 for exactly this cycle, then go to WAIT unconditionally.
- WAIT
  - On `dp_done` = 1, go to ACK.
  - Otherwise stay in WAIT, subject to the watchdog.
- ACK
  - `ack` = `grant` for this cycle.
  - `ptr` ← (winner index + 1) mod N.
  - Go to IDLE. `grant` clears on the transition.
- `ptr` is a log2(N)-bit register, reset to 0. It advances only in ACK.
- Fairness: a requester that stays pending is served within N jobs.
- `dp_done` is honoured only in WAIT. It is ignored in IDLE, ISSUE and ACK, including a `dp_done` coincident with `dp_start`.
- If a requester drops `req` mid-job, the job still completes and `ack` still pulses. No cancel exists.
- `req` still high when IDLE samples it counts as a new job. Requesters must drop `req` on the edge at which they sample `ack` = 1.
- Changes to `req` while `busy` have no effect until IDLE.
- Reset (asserted at any time, including mid-job): state = IDLE, `grant` = 0, `ack` = 0, `dp_start` = 0, `busy` = 0, `timeout_err` = 0, `ptr` = 0, watchdog counter = 0. The job in flight is abandoned and no `ack` is issued.

## Timing
- Edge E0 samples a nonzero `req` in IDLE. After E0: `grant` and `busy` are valid and `dp_start` = 1.
- After E1: `dp_start` = 0 and the state is WAIT.
- Edge Ed samples `dp_done` = 1 in WAIT. After Ed: `ack` = 1 for one cycle.
- After Ed+1: IDLE, with `grant`, `ack` and `busy` all 0.
- The next arbitration is sampled no earlier than Ed+2. Minimum job occupancy is 3 cycles plus the datapath latency.

## Configuration
- Macro `ARB_TIMEOUT_EN`, defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle without `dp_done`.
  - On the edge where the counter equals TIMEOUT-1 and `dp_done` = 0, go to ACK with `timeout_err` = 1, valid together with `ack`.
  - If `dp_done` and the timeout coincide, `dp_done` wins and `timeout_err` = 0.
  - WAIT lasts at most TIMEOUT cycles.
- Not defined: no counter is built, `timeout_err` is tied to 0, and WAIT waits indefinitely for `dp_done`.

## Test plan
Common setup: N = 4, TIMEOUT = 8, clock period 10. Stub datapath returns `dp_done` 5 cycles after `dp_start`. `rst_n` is low for the first 10 time units.

- Single request: `req` = 0001 at t = 50 → `grant` = 0001 and one `dp_start` pulse; `ack` = 0001 for one cycle 7 cycles after the sampling edge; `busy` falls the cycle after.
- Round-robin: `req` = 1111 held, each bit dropped on its `ack` → grant order 0001, 0010, 0100, 1000. Then re-raise `req` = 1001 → grant 0001 (ptr wrapped to 0).
- Fairness: `req[0]` re-raised immediately after each `ack`, `req[2]` held → grants alternate 0001, 0100.
- Stray done: `dp_done` pulsed in IDLE and in the ISSUE cycle → no state change; `ack` only after the stub's real `dp_done`.
- Reset mid-job: `rst_n` low during WAIT → all outputs 0 immediately (asynchronous); no `ack`; after release, pending `req` = 0100 is granted from ptr = 0.
- Timeout, with `ARB_TIMEOUT_EN` defined and the stub never answering → `ack` and `timeout_err` = 1 on the 8th WAIT cycle. Without the macro, `busy` stays 1 and `timeout_err` stays 0.
